pc_sequencer: RTL and testbench

Parametrised successor to the PC/nPC register pair for the SPARCv8 core. It holds PC and nPC and implements the delayed control-transfer semantics:
- sequential advance, delayed branch/jump, annulled delay slot
- direct load, and a two-cycle trap-entry sequence that saves PC/nPC before vectoring

It sits between the control unit, which drives the request strobes, and the address bus / register-file write path.

---
 rtl/pc_sequencer.sv | 131 +++++++++++++
 tb/tb_pc_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`timescale 1ns/1ps
// pc_sequencer
//   Holds the SPARCv8 PC/nPC pair and implements delayed control transfer,
//   annulled delay slots, direct load and a two-cycle trap entry
//   (save PC/nPC, then vector).
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   step         retire current instruction, advance PC/nPC
//   xfer         with step: delayed control transfer to xfer_target
//   xfer_target  transfer destination (must be word aligned)
//   annul        with step: annul the next instruction
//   ld           direct load of PC from ld_pc
//   ld_pc        direct-load value
//   trap_req     trap request, level, held until trap_ack
//   trap_vec     trap vector, stable from trap_req until trap_ack
//   pc, npc      current and next PC
//   slot_annul   instruction at pc is annulled
//   saved_pc     PC captured at trap entry
//   saved_npc    nPC captured at trap entry
//   busy         trap sequence in progress
//   trap_ack     one-cycle pulse, trap vector loaded
//   align_err    one-cycle pulse, misaligned transfer suppressed
//   fsm_state    current sequencer state (RUN=0, TRAP_SAVE=1, TRAP_VEC=2)
//
// Handshake: trap_req is a level request; the sequencer answers with a
// single-cycle trap_ack in the cycle the vector PC becomes visible. A
// request still high in that cycle is taken as a new trap.

module pc_sequencer #(
   parameter int          AW       = 32,
   parameter logic [AW-1:0] RESET_PC = '0,
   parameter int          INC      = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          step,
   input  logic          xfer,
   input  logic [AW-1:0] xfer_target,
   input  logic          annul,
   input  logic          ld,
   input  logic [AW-1:0] ld_pc,
   input  logic          trap_req,
   input  logic [AW-1:0] trap_vec,
   output logic [AW-1:0] pc,
   output logic [AW-1:0] npc,
   output logic          slot_annul,
   output logic [AW-1:0] saved_pc,
   output logic [AW-1:0] saved_npc,
   output logic          busy,
   output logic          trap_ack,
   output logic          align_err,
   output logic [1:0]    fsm_state
);

   localparam logic [AW-1:0] INC_W = AW'(INC);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      TRAP_SAVE = 2'd1,
      TRAP_VEC  = 2'd2
   } state_t;

   state_t state;

   assign busy      = (state != RUN);
   assign fsm_state = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= RUN;
         pc         <= RESET_PC;
         npc        <= RESET_PC + INC_W;
         slot_annul <= 1'b0;
         saved_pc   <= '0;
         saved_npc  <= '0;
         trap_ack   <= 1'b0;
         align_err  <= 1'b0;
      end else begin
         trap_ack  <= 1'b0;
         align_err <= 1'b0;
         case (state)
            RUN: begin
               if (trap_req) begin
                  // The trap wins over a simultaneous step: that instruction
                  // is not retired, so pc/npc are saved as they stand.
                  state <= TRAP_SAVE;
               end else if (ld) begin
                  pc         <= ld_pc;
                  npc        <= ld_pc + INC_W;
                  slot_annul <= 1'b0;
               end else if (step) begin
                  if (slot_annul) begin
                     // Annulled instruction: plain advance, xfer/annul dropped.
                     pc         <= npc;
                     npc        <= npc + INC_W;
                     slot_annul <= 1'b0;
                  end else if (!xfer) begin
                     pc         <= npc;
                     npc        <= npc + INC_W;
                     slot_annul <= annul;
                  end else if (xfer_target[1:0] == 2'b00) begin
                     pc         <= npc;
                     npc        <= xfer_target;
                     slot_annul <= annul;
                  end else begin
                     // Misaligned target: nothing moves; control logic
                     // follows up with a trap request.
                     align_err <= 1'b1;
                  end
               end
            end
            TRAP_SAVE: begin
               saved_pc  <= pc;
               saved_npc <= npc;
               state     <= TRAP_VEC;
            end
            TRAP_VEC: begin
               pc         <= trap_vec;
               npc        <= trap_vec + INC_W;
               slot_annul <= 1'b0;
               trap_ack   <= 1'b1;
               state      <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps
// Directed bench for pc_sequencer (AW=32, RESET_PC=0, INC=4).
// Expected snapshots are queued as each step is driven and popped/compared
// after the clock edge that should produce them.

module tb_pc_sequencer;

   localparam int AW = 32;
   localparam int W  = 4*AW + 4;

   logic          clk;
   logic          rst;
   logic          step;
   logic          xfer;
   logic [AW-1:0] xfer_target;
   logic          annul;
   logic          ld;
   logic [AW-1:0] ld_pc;
   logic          trap_req;
   logic [AW-1:0] trap_vec;
   logic [AW-1:0] pc;
   logic [AW-1:0] npc;
   logic          slot_annul;
   logic [AW-1:0] saved_pc;
   logic [AW-1:0] saved_npc;
   logic          busy;
   logic          trap_ack;
   logic          align_err;
   logic [1:0]    fsm_state;

   logic [W-1:0] exp_q[$];
   string        tag_q[$];
   int           n_compared;
   int           n_mismatched;

   pc_sequencer #(.AW(AW), .RESET_PC('0), .INC(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .step        (step),
      .xfer        (xfer),
      .xfer_target (xfer_target),
      .annul       (annul),
      .ld          (ld),
      .ld_pc       (ld_pc),
      .trap_req    (trap_req),
      .trap_vec    (trap_vec),
      .pc          (pc),
      .npc         (npc),
      .slot_annul  (slot_annul),
      .saved_pc    (saved_pc),
      .saved_npc   (saved_npc),
      .busy        (busy),
      .trap_ack    (trap_ack),
      .align_err   (align_err),
      .fsm_state   (fsm_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   function automatic logic [W-1:0] snap(input logic [AW-1:0] p, input logic [AW-1:0] n,
                                         input logic sa, input logic b, input logic a,
                                         input logic e, input logic [AW-1:0] sp,
                                         input logic [AW-1:0] sn);
      return {p, n, sa, b, a, e, sp, sn};
   endfunction

   task automatic expect_state(input string tag, input logic [W-1:0] e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic compare_now();
      logic [W-1:0] obs;
      logic [W-1:0] e;
      string        t;
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      obs = {pc, npc, slot_annul, busy, trap_ack, align_err, saved_pc, saved_npc};
      n_compared++;
      assert (obs === e) else begin
         n_mismatched++;
         $error("FAIL %s observed pc=%h npc=%h sa=%b busy=%b ack=%b aerr=%b spc=%h snpc=%h expected %h",
                t, pc, npc, slot_annul, busy, trap_ack, align_err, saved_pc, saved_npc, e);
      end
   endtask

   // queue expectation, advance one edge, sample #1 after it
   task automatic tick(input string tag, input logic [W-1:0] e);
      expect_state(tag, e);
      @(posedge clk);
      #1;
      compare_now();
   endtask

   task automatic idle();
      step = 0; xfer = 0; xfer_target = '0; annul = 0;
      ld = 0; ld_pc = '0; trap_req = 0; trap_vec = '0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      idle();
      rst = 1'b0;
      #12;
      expect_state("reset", snap(32'h0, 32'h4, 0, 0, 0, 0, 32'h0, 32'h0));
      compare_now();
      @(negedge clk);
      rst = 1'b1;

      // sequential advance
      step = 1;
      tick("step1", snap(32'h4,  32'h8,  0, 0, 0, 0, 32'h0, 32'h0));
      tick("step2", snap(32'h8,  32'hC,  0, 0, 0, 0, 32'h0, 32'h0));
      tick("step3", snap(32'hC,  32'h10, 0, 0, 0, 0, 32'h0, 32'h0));

      // direct load beats step
      ld = 1; ld_pc = 32'h8;
      tick("ld8", snap(32'h8, 32'hC, 0, 0, 0, 0, 32'h0, 32'h0));
      ld = 0;

      // delayed branch
      xfer = 1; xfer_target = 32'h100;
      tick("branch", snap(32'hC, 32'h100, 0, 0, 0, 0, 32'h0, 32'h0));
      xfer = 0;
      tick("branch_tgt", snap(32'h100, 32'h104, 0, 0, 0, 0, 32'h0, 32'h0));

      // annulled delay slot
      step = 0; ld = 1; ld_pc = 32'h0;
      tick("ld0", snap(32'h0, 32'h4, 0, 0, 0, 0, 32'h0, 32'h0));
      ld = 0; step = 1; xfer = 1; annul = 1; xfer_target = 32'h40;
      tick("xfer_annul", snap(32'h4, 32'h40, 1, 0, 0, 0, 32'h0, 32'h0));
      annul = 0; xfer_target = 32'h80;
      tick("annulled_slot", snap(32'h40, 32'h44, 0, 0, 0, 0, 32'h0, 32'h0));
      xfer = 0; annul = 1;
      tick("annul_noxfer", snap(32'h44, 32'h48, 1, 0, 0, 0, 32'h0, 32'h0));
      annul = 0; ld = 1; ld_pc = 32'h20;
      tick("ld_clears_annul", snap(32'h20, 32'h24, 0, 0, 0, 0, 32'h0, 32'h0));
      ld = 0;

      // trap with simultaneous step; step held through busy is ignored
      trap_req = 1; trap_vec = 32'h800; step = 1;
      tick("trap_save", snap(32'h20, 32'h24, 0, 1, 0, 0, 32'h0, 32'h0));
      tick("trap_vec", snap(32'h20, 32'h24, 0, 1, 0, 0, 32'h20, 32'h24));
      tick("trap_ack", snap(32'h800, 32'h804, 0, 0, 1, 0, 32'h20, 32'h24));
      trap_req = 0; step = 0;
      tick("post_trap", snap(32'h800, 32'h804, 0, 0, 0, 0, 32'h20, 32'h24));

      // misaligned transfer
      step = 1; xfer = 1; xfer_target = 32'h102;
      tick("misalign", snap(32'h800, 32'h804, 0, 0, 0, 1, 32'h20, 32'h24));
      step = 0; xfer = 0;
      tick("misalign_done", snap(32'h800, 32'h804, 0, 0, 0, 0, 32'h20, 32'h24));

      // back-to-back trap: request still high in the ack cycle
      trap_req = 1; trap_vec = 32'h900;
      tick("t2_save", snap(32'h800, 32'h804, 0, 1, 0, 0, 32'h20, 32'h24));
      tick("t2_vec", snap(32'h800, 32'h804, 0, 1, 0, 0, 32'h800, 32'h804));
      tick("t2_ack", snap(32'h900, 32'h904, 0, 0, 1, 0, 32'h800, 32'h804));
      tick("t3_save", snap(32'h900, 32'h904, 0, 1, 0, 0, 32'h800, 32'h804));
      trap_req = 0;
      tick("t3_vec", snap(32'h900, 32'h904, 0, 1, 0, 0, 32'h900, 32'h904));
      tick("t3_ack", snap(32'h900, 32'h904, 0, 0, 1, 0, 32'h900, 32'h904));

      // wrap
      ld = 1; ld_pc = 32'hFFFF_FFFC;
      tick("ld_top", snap(32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0, 32'h900, 32'h904));
      ld = 0; step = 1;
      tick("wrap", snap(32'h0, 32'h4, 0, 0, 0, 0, 32'h900, 32'h904));
      step = 0;

      // reset during TRAP_SAVE
      trap_req = 1; trap_vec = 32'hA00;
      tick("t4_save", snap(32'h0, 32'h4, 0, 1, 0, 0, 32'h900, 32'h904));
      rst = 1'b0;
      #1;
      expect_state("reset_mid_trap", snap(32'h0, 32'h4, 0, 0, 0, 0, 32'h0, 32'h0));
      compare_now();
      trap_req = 0;
      @(negedge clk);
      rst = 1'b1;
      tick("after_reset", snap(32'h0, 32'h4, 0, 0, 0, 0, 32'h0, 32'h0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
